// File: rtl/dfh_chain_walker.sv
// dfh_chain_walker
//   Walks the Device Feature Header linked list in CSR space. On an accepted
//   start it reads the DFH at base_addr through a single-outstanding read
//   port. It records each header in a small table and follows nxt_dfh_offset
//   until EOL or a fault: timeout, zero offset, table overflow or address wrap.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   start, base_addr              walk launch (ignored while busy)
//   busy, done                    walk in progress / one-cycle end pulse
//   error, err_code, num_feat     result of the last walk (held until next start)
//   rd_req_valid/ready/addr       DFH read request
//   rd_rsp_valid, rd_rsp_data     DFH read response
//   tbl_idx, tbl_data             registered table read port
module dfh_chain_walker #(
    parameter int ADDR_W      = 32,
    parameter int MAX_FEAT    = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int IDX_W       = $clog2(MAX_FEAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [IDX_W-1:0]  num_feat,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [63:0]       rd_rsp_data,
    input  logic [IDX_W-1:0]  tbl_idx,
    output logic [63:0]       tbl_data
);
    // The adder is wide enough for both operands. Any bit at or above ADDR_W
    // flags a wrap, even when ADDR_W is narrower than the 24-bit offset.
    localparam int SUM_W = ((ADDR_W > 24) ? ADDR_W : 24) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int TI_W  = $clog2(MAX_FEAT);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  cur_addr;
    logic [IDX_W-1:0]   count;
    logic [TMR_W-1:0]   timer;
    logic [63:0]        tbl [MAX_FEAT];

    // Only the decoded fields of the captured DFH are kept.
    logic [3:0]  d_type, d_minor, d_major;
    logic        d_eol;
    logic [23:0] d_nxt;
    logic [11:0] d_id;

    logic [SUM_W-1:0]  sum;
    logic              wrap, timeout, eval_stop;
    logic [IDX_W-1:0]  count_inc;
    logic [2:0]        eval_err;
    logic [31:0]       off32;
    logic [63:0]       entry;

    assign sum       = SUM_W'(cur_addr) + SUM_W'(d_nxt);
    assign wrap      = |sum[SUM_W-1:ADDR_W];
    assign count_inc = count + IDX_W'(1);
    // timer counts cycles since the accepting cycle. The acceptance cycle is 0.
    assign timeout   = (timer == TMR_W'(TIMEOUT_CYC - 1));

    generate
        if (ADDR_W >= 32) begin : g_off_trunc
            assign off32 = cur_addr[31:0];
        end else begin : g_off_zext
            assign off32 = {{(32 - ADDR_W){1'b0}}, cur_addr};
        end
    endgenerate

    assign entry = {d_type, d_minor, d_major, d_eol, 7'b0, d_id, off32};

    // EVAL checks are ordered: eol > zero offset > overflow > wrap.
    always_comb begin
        eval_err  = 3'd0;
        eval_stop = 1'b1;
        if (d_eol)                            eval_err = 3'd0;
        else if (d_nxt == 24'd0)              eval_err = 3'd2;
        else if (count_inc == IDX_W'(MAX_FEAT)) eval_err = 3'd3;
        else if (wrap)                        eval_err = 3'd4;
        else                                  eval_stop = 1'b0;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start)        state_nxt = S_REQ;
            S_REQ:  if (rd_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (rd_rsp_valid) state_nxt = S_EVAL;
                else if (timeout) state_nxt = S_DONE;
            end
            S_EVAL: state_nxt = eval_stop ? S_DONE : S_REQ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        rd_req_valid = (state == S_REQ);
    end

    assign rd_req_addr = {cur_addr[ADDR_W-1:3], 3'b000};

    // walk datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= '0;
            count    <= '0;
            timer    <= '0;
            error    <= 1'b0;
            err_code <= 3'd0;
            num_feat <= '0;
            d_type   <= '0;
            d_minor  <= '0;
            d_major  <= '0;
            d_eol    <= 1'b0;
            d_nxt    <= '0;
            d_id     <= '0;
            tbl_data <= '0;
        end else begin
            tbl_data <= (tbl_idx < IDX_W'(MAX_FEAT)) ? tbl[tbl_idx[TI_W-1:0]] : 64'd0;
            unique case (state)
                S_IDLE: if (start) begin
                    cur_addr <= base_addr;
                    count    <= '0;
                    error    <= 1'b0;
                    err_code <= 3'd0;
                end
                S_REQ: timer <= TMR_W'(1);
                S_WAIT: begin
                    if (rd_rsp_valid) begin
                        d_type  <= rd_rsp_data[63:60];
                        d_minor <= rd_rsp_data[51:48];
                        d_eol   <= rd_rsp_data[40];
                        d_nxt   <= rd_rsp_data[39:16];
                        d_major <= rd_rsp_data[15:12];
                        d_id    <= rd_rsp_data[11:0];
                    end else if (timeout) begin
                        error    <= 1'b1;
                        err_code <= 3'd1;
                        num_feat <= count;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_EVAL: begin
                    count <= count_inc;
                    if (eval_stop) begin
                        error    <= (eval_err != 3'd0);
                        err_code <= eval_err;
                        num_feat <= count_inc;
                    end else begin
                        cur_addr <= sum[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Feature table is not reset. Stale entries past num_feat are expected.
    always_ff @(posedge clk) begin
        if (state == S_EVAL) tbl[count[TI_W-1:0]] <= entry;
    end
endmodule

// File: tb/tb_dfh_chain_walker.sv
module tb_dfh_chain_walker;
    localparam int AW = 16;
    localparam int MF = 4;
    localparam int TO = 64;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, error;
    logic [AW-1:0] base_addr, rd_req_addr;
    logic [2:0]    err_code;
    logic [IW-1:0] num_feat, tbl_idx;
    logic          rd_req_valid, rd_req_ready, rd_rsp_valid;
    logic [63:0]   rd_rsp_data, tbl_data;

    always #5 clk = ~clk;

    dfh_chain_walker #(.ADDR_W(AW), .MAX_FEAT(MF), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .num_feat(num_feat), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .tbl_idx(tbl_idx), .tbl_data(tbl_data)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] mem [int];
    logic        rsp_en = 1'b1;
    logic        force_rsp = 1'b0;
    logic [63:0] force_data = 64'd0;

    function automatic logic [63:0] dfh(input logic [3:0] ty, input logic [3:0] mn,
                                        input logic [3:0] mj, input logic eol,
                                        input logic [23:0] nxt, input logic [11:0] id);
        logic [63:0] d;
        d        = 64'd0;
        d[63:60] = ty;
        d[59:52] = 8'hA5;   // reserved noise, must not appear in the table
        d[51:48] = mn;
        d[47:41] = 7'h5A;
        d[40]    = eol;
        d[39:16] = nxt;
        d[15:12] = mj;
        d[11:0]  = id;
        return d;
    endfunction

    function automatic logic [63:0] rd_mem(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 64'd0;
    endfunction

    // Zero-wait responder: a request accepted at one edge is answered in the
    // cycle right after it.
    initial begin
        logic          acc;
        logic [AW-1:0] a;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = 64'd0;
        forever begin
            @(negedge clk); #1;
            acc = rsp_en && rd_req_valid && rd_req_ready;
            a   = rd_req_addr;
            @(posedge clk); #1;
            rd_rsp_valid = acc | force_rsp;
            rd_rsp_data  = acc ? rd_mem(a) : force_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic walk(input logic [AW-1:0] base, output int cyc);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        cyc       = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic rd_tbl(input logic [IW-1:0] idx, output logic [63:0] d);
        @(negedge clk);
        tbl_idx = idx;
        @(negedge clk);
        d = tbl_data;
    endtask

    initial begin
        int          cyc, stable, dc;
        logic [63:0] d;
        rst = 1'b0; start = 1'b0; base_addr = '0; rd_req_ready = 1'b1; tbl_idx = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_ctl", {busy, done, error, err_code, rd_req_valid}, 64'd0);
        chk("rst_num_feat", num_feat, 0);
        chk("rst_req_addr", rd_req_addr, 0);
        chk("rst_tbl_data", tbl_data, 0);
        @(negedge clk); rst = 1'b0;

        // Clean chain of three headers at 0x0, 0x1000 and 0x3000.
        mem.delete();
        mem[32'h0000] = dfh(4'h3, 4'h0, 4'h1, 1'b0, 24'h1000, 12'h000);
        mem[32'h1000] = dfh(4'h3, 4'h1, 4'h2, 1'b0, 24'h2000, 12'h001);
        mem[32'h3000] = dfh(4'h4, 4'h2, 4'h0, 1'b1, 24'h0000, 12'h014);
        walk(16'h0000, cyc);
        chk("clean_done_cyc", cyc, 10);
        chk("clean_result", {error, err_code}, 0);
        chk("clean_num_feat", num_feat, 3);
        rd_tbl(0, d); chk("clean_ent0", d, {4'h3, 4'h0, 4'h1, 1'b0, 7'b0, 12'h000, 32'h0000});
        rd_tbl(1, d); chk("clean_ent1", d, {4'h3, 4'h1, 4'h2, 1'b0, 7'b0, 12'h001, 32'h1000});
        rd_tbl(2, d); chk("clean_ent2", d, {4'h4, 4'h2, 4'h0, 1'b1, 7'b0, 12'h014, 32'h3000});
        rd_tbl(5, d); chk("tbl_oob_zero", d, 0);

        // Broken chain: second header has offset 0 and no EOL.
        mem.delete();
        mem[32'h0000] = dfh(4'h1, 4'h0, 4'h0, 1'b0, 24'h0100, 12'h007);
        mem[32'h0100] = dfh(4'h1, 4'h0, 4'h0, 1'b0, 24'h0000, 12'h008);
        walk(16'h0000, cyc);
        chk("broken_done_cyc", cyc, 7);
        chk("broken_result", {error, err_code}, {1'b1, 3'd2});
        chk("broken_num_feat", num_feat, 2);

        // Overflow: six-header chain into a four-entry table.
        mem.delete();
        for (int i = 0; i < 6; i++)
            mem[i * 'h40] = dfh(4'h2, 4'h0, 4'h0, 1'b0, 24'h0040, 12'(12'h020 + i));
        walk(16'h0000, cyc);
        chk("ovf_done_cyc", cyc, 13);
        chk("ovf_result", {error, err_code}, {1'b1, 3'd3});
        chk("ovf_num_feat", num_feat, 4);
        rd_tbl(3, d); chk("ovf_ent3", d, {4'h2, 4'h0, 4'h0, 1'b0, 7'b0, 12'h023, 32'h00C0});

        // EOL on the last table slot wins over overflow and zero offset.
        mem.delete();
        for (int i = 0; i < 4; i++)
            mem[i * 'h10] = dfh(4'h5, 4'h0, 4'h0, i == 3, (i == 3) ? 24'h0 : 24'h10, 12'(i));
        walk(16'h0000, cyc);
        chk("full_eol_done_cyc", cyc, 13);
        chk("full_eol_result", {error, err_code}, 0);
        chk("full_eol_num_feat", num_feat, 4);

        // Timeout with 20 cycles of request backpressure and no response.
        @(negedge clk);
        rd_req_ready = 1'b0; rsp_en = 1'b0; start = 1'b1; base_addr = 16'h0800;
        @(negedge clk);
        start = 1'b0;
        chk("to_err_cleared", error, 0);
        stable = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (rd_req_valid === 1'b1 && rd_req_addr === 16'h0800) stable++;
        end
        chk("to_stall_stable", stable, 20);
        @(negedge clk);
        chk("to_req_still_valid", {rd_req_valid, rd_req_addr}, {1'b1, 16'h0800});
        rd_req_ready = 1'b1;
        dc = -1;
        for (int c = 22; c <= 300; c++) begin
            @(negedge clk);
            if (done) begin
                dc = c;
                break;
            end
        end
        chk("to_done_cyc", dc, 21 + TO);
        chk("to_result", {error, err_code}, {1'b1, 3'd1});
        chk("to_num_feat", num_feat, 0);
        rsp_en = 1'b1;

        // Address wrap out of the 16-bit space.
        mem.delete();
        mem[32'hF000] = dfh(4'h6, 4'h0, 4'h0, 1'b0, 24'h2000, 12'h055);
        walk(16'hF000, cyc);
        chk("wrap_done_cyc", cyc, 4);
        chk("wrap_result", {error, err_code}, {1'b1, 3'd4});
        chk("wrap_num_feat", num_feat, 1);
        rd_tbl(0, d); chk("wrap_ent0", d, {4'h6, 4'h0, 4'h0, 1'b0, 7'b0, 12'h055, 32'hF000});

        // Reset during WAIT, a stray response, then a fresh clean walk.
        mem.delete();
        mem[32'h0000] = dfh(4'h3, 4'h0, 4'h1, 1'b0, 24'h1000, 12'h000);
        mem[32'h1000] = dfh(4'h3, 4'h1, 4'h2, 1'b0, 24'h2000, 12'h001);
        mem[32'h3000] = dfh(4'h4, 4'h2, 4'h0, 1'b1, 24'h0000, 12'h014);
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rw_in_wait", {busy, rd_req_valid}, {1'b1, 1'b0});
        rst = 1'b1;
        #1;
        chk("rw_rst_ctl", {busy, done, error, err_code, rd_req_valid}, 64'd0);
        chk("rw_rst_num_feat", num_feat, 0);
        chk("rw_rst_tbl_data", tbl_data, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        force_rsp = 1'b1; force_data = dfh(4'hF, 4'h0, 4'h0, 1'b1, 24'h0, 12'hFFF);
        @(negedge clk);
        force_rsp = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rw_stray_ignored", {busy, done, rd_req_valid}, 0);
        walk(16'h0000, cyc);
        chk("rw_done_cyc", cyc, 10);
        chk("rw_result", {error, err_code}, 0);
        chk("rw_num_feat", num_feat, 3);
        rd_tbl(2, d); chk("rw_ent2", d, {4'h4, 4'h2, 4'h0, 1'b1, 7'b0, 12'h014, 32'h3000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
